// File: rtl/hamming_tx_serializer.sv
// Hamming(12,8) even-parity encoder with optional single-bit fault injection, plus a serializer that sends position 12 first.
// Latency: a byte accepted at edge k with the FSM idle drives codeword bit 12 from edge k+1; each bit is held CLKS_PER_BIT cycles.
// Backpressure: one-entry holding register; in_ready = !hold_full, and in_valid is ignored while the holding register is occupied.
module hamming_tx_serializer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:1]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        inj_en,
  input  logic [3:0]  inj_pos,
  output logic        ser_out,
  output logic        ser_frame,
  output logic        frame_done,
  output logic        busy,
  output logic [12:1] cw_out
);

  // Counter widths are clamped to 1 bit so that CLKS_PER_BIT = 1 and GAP_BITS = 0 still elaborate.
  localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GAP_CYC = (GAP_BITS > 0) ? GAP_BITS * CLKS_PER_BIT : 1;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam bit NO_GAP  = (GAP_BITS == 0);

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [3:0]       BIT_LAST = 4'd11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [12:1]      hold_cw_q, hold_cw_d;
  logic [12:1]      sh_q, sh_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [12:1]      cw_q, cw_d;

  logic [12:1] enc_cw;
  logic [12:1] inj_mask;
  logic        accept;
  logic        bit_end;
  logic        frame_end;
  logic        gap_end;
  logic        load;

  // Even-parity Hamming(12,8) encoding of the byte on the input port.
  always_comb begin
    enc_cw     = '0;
    enc_cw[3]  = in_data[1];
    enc_cw[5]  = in_data[2];
    enc_cw[6]  = in_data[3];
    enc_cw[7]  = in_data[4];
    enc_cw[9]  = in_data[5];
    enc_cw[10] = in_data[6];
    enc_cw[11] = in_data[7];
    enc_cw[12] = in_data[8];
    enc_cw[1]  = in_data[1] ^ in_data[2] ^ in_data[4] ^ in_data[5] ^ in_data[7];
    enc_cw[2]  = in_data[1] ^ in_data[3] ^ in_data[4] ^ in_data[6] ^ in_data[7];
    enc_cw[4]  = in_data[2] ^ in_data[3] ^ in_data[4] ^ in_data[8];
    enc_cw[8]  = in_data[5] ^ in_data[6] ^ in_data[7] ^ in_data[8];
  end

  // One-hot flip mask; positions 0 and 13..15 match no bit, so they produce no flip.
  always_comb begin
    inj_mask = '0;
    for (int i = 1; i <= 12; i++) begin
      inj_mask[i] = inj_en && (inj_pos == 4'(i));
    end
  end

  assign accept    = in_valid && !hold_full_q;
  assign bit_end   = (cyc_q == CYC_LAST);
  assign frame_end = (state_q == S_SHIFT) && bit_end && (bit_q == BIT_LAST);
  assign gap_end   = (state_q == S_GAP) && (gap_q == GAP_LAST);
  // A held word starts from IDLE, straight after a frame when there is no gap, or at the end of the gap.
  assign load      = hold_full_q && ((state_q == S_IDLE) || (frame_end && NO_GAP) || gap_end);

  // Next-state logic: holding register fill, bit/cycle/gap counting and frame reload.
  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_cw_d   = hold_cw_q;
    sh_d        = sh_q;
    bit_d       = bit_q;
    cyc_d       = cyc_q;
    gap_d       = gap_q;
    cw_d        = cw_q;

    // accept needs an empty hold and load needs a full one, so they never coincide.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_cw_d   = enc_cw ^ inj_mask;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_SHIFT: begin
        if (bit_end) begin
          cyc_d = '0;
          sh_d  = {sh_q[11:1], 1'b1};
          bit_d = bit_q + 4'd1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            gap_d   = '0;
            state_d = NO_GAP ? S_IDLE : S_GAP;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      state_d     = S_SHIFT;
      sh_d        = hold_cw_q;
      cw_d        = hold_cw_q;
      bit_d       = '0;
      cyc_d       = '0;
      hold_full_d = 1'b0;
    end
  end

  // State registers; reset aborts any frame in flight and discards the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      hold_cw_q   <= '0;
      sh_q        <= '1;
      bit_q       <= '0;
      cyc_q       <= '0;
      gap_q       <= '0;
      cw_q        <= '0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_cw_q   <= hold_cw_d;
      sh_q        <= sh_d;
      bit_q       <= bit_d;
      cyc_q       <= cyc_d;
      gap_q       <= gap_d;
      cw_q        <= cw_d;
    end
  end

  assign in_ready   = !hold_full_q;
  assign ser_out    = (state_q == S_SHIFT) ? sh_q[12] : 1'b1;
  assign ser_frame  = (state_q == S_SHIFT);
  assign frame_done = frame_end;
  assign busy       = (state_q != S_IDLE);
  assign cw_out     = cw_q;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: three instances (4/1, 4/0 and 1/0 clocks-per-bit/gap-bits).
// Expected codewords are queued when a byte is handed over and compared when a frame completes.
// The serial stream is rebuilt and decoded by a reference syndrome decoder.
module tb_hamming_tx_serializer;

  logic clk;
  logic rst;

  logic [8:1]  in_data      [3];
  logic        in_valid     [3];
  logic        in_ready_w   [3];
  logic        inj_en       [3];
  logic [3:0]  inj_pos      [3];
  logic        ser_out_w    [3];
  logic        ser_frame_w  [3];
  logic        frame_done_w [3];
  logic        busy_w       [3];
  logic [12:1] cw_out_w     [3];

  hamming_tx_serializer #(.CLKS_PER_BIT(4), .GAP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .inj_en(inj_en[0]), .inj_pos(inj_pos[0]), .ser_out(ser_out_w[0]), .ser_frame(ser_frame_w[0]),
    .frame_done(frame_done_w[0]), .busy(busy_w[0]), .cw_out(cw_out_w[0]));

  hamming_tx_serializer #(.CLKS_PER_BIT(4), .GAP_BITS(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .inj_en(inj_en[1]), .inj_pos(inj_pos[1]), .ser_out(ser_out_w[1]), .ser_frame(ser_frame_w[1]),
    .frame_done(frame_done_w[1]), .busy(busy_w[1]), .cw_out(cw_out_w[1]));

  hamming_tx_serializer #(.CLKS_PER_BIT(1), .GAP_BITS(0)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .inj_en(inj_en[2]), .inj_pos(inj_pos[2]), .ser_out(ser_out_w[2]), .ser_frame(ser_frame_w[2]),
    .frame_done(frame_done_w[2]), .busy(busy_w[2]), .cw_out(cw_out_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] cw;
  } sb_t;

  typedef struct {
    logic [7:0]  data;
    logic        en;
    logic [3:0]  pos;
    logic [11:0] cw;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[10];

  int n_chk;
  int n_fail;
  int fcnt[3];
  int run[3];
  int lowrun[3];
  int last_run[3];
  int last_gap[3];
  int ndone[3];
  logic [11:0] cap[3];

  function automatic int cpb_of(input int g);
    return (g == 2) ? 1 : 4;
  endfunction

  // Reference encoder written from the generic Hamming rule: parity bit b covers every position with bit b set.
  function automatic logic [11:0] tb_encode(input logic [7:0] d);
    logic [11:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int b = 1; b <= 8; b = b * 2) begin
      logic x;
      x = 1'b0;
      for (int p = 1; p <= 12; p++) begin
        if (p != b && (p & b) != 0) x = x ^ c[p-1];
      end
      c[b-1] = x;
    end
    return c;
  endfunction

  // Receive-side decoder: syndrome points at the flipped position, which is corrected before extraction.
  function automatic logic [7:0] tb_decode(input logic [11:0] cw);
    logic [11:0] c;
    logic [7:0]  d;
    int s;
    int k;
    c = cw;
    s = 0;
    for (int p = 1; p <= 12; p++) begin
      if (c[p-1]) s = s ^ p;
    end
    if (s >= 1 && s <= 12) c[s-1] = ~c[s-1];
    d = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = c[p-1];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [11:0] pos_mask(input int pos);
    logic [11:0] m;
    m = '0;
    if (pos >= 1 && pos <= 12) m[pos-1] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not happen as required at %0t", nm, $time);
  endtask

  // Per-cycle observation of every instance: rebuilds frames and checks them against the scoreboard.
  task automatic mon();
    sb_t e;
    for (int g = 0; g < 3; g++) begin
      int cpb;
      cpb = cpb_of(g);
      if (rst) begin
        fcnt[g] = 0;
        run[g] = 0;
        lowrun[g] = 0;
        continue;
      end
      if (ser_frame_w[g]) begin
        if (run[g] == 0) last_gap[g] = lowrun[g];
        run[g]++;
        lowrun[g] = 0;
        chk("busy_in_frame", int'(busy_w[g]), 1);
        if (fcnt[g] % cpb == 0) cap[g] = {cap[g][10:0], ser_out_w[g]};
        else chk("bit_hold", int'(ser_out_w[g]), int'(cap[g][0]));
        chk("frame_done_pos", int'(frame_done_w[g]), int'(fcnt[g] == 12 * cpb - 1));
        if (frame_done_w[g]) begin
          fcnt[g] = 0;
          ndone[g]++;
          if (sbq.size() == 0) begin
            flag("unexpected_frame");
          end else begin
            e = sbq.pop_front();
            chk("serial_cw", int'(cap[g]), int'(e.cw));
            chk("cw_out", int'(cw_out_w[g]), int'(e.cw));
            chk("decoded", int'(tb_decode(cap[g])), int'(e.data));
          end
        end else begin
          fcnt[g]++;
        end
      end else begin
        if (run[g] > 0) last_run[g] = run[g];
        run[g] = 0;
        lowrun[g]++;
        chk("idle_ser_out", int'(ser_out_w[g]), 1);
        chk("idle_frame_done", int'(frame_done_w[g]), 0);
        if (fcnt[g] != 0) flag("truncated_frame");
        fcnt[g] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
  endtask

  // Offer a byte and wait for the handshake; in_valid is left high so streams stay back to back.
  task automatic send(input int g, input logic [7:0] d, input logic en, input logic [3:0] pos,
                      input logic [11:0] exp_cw);
    sb_t e;
    int t;
    in_data[g]  = d;
    inj_en[g]   = en;
    inj_pos[g]  = pos;
    in_valid[g] = 1'b1;
    t = 0;
    while (!in_ready_w[g] && t < 2000) begin
      cyc();
      t++;
    end
    if (!in_ready_w[g]) begin
      flag("send_ready_timeout");
    end else begin
      e.data = d;
      e.cw   = exp_cw;
      sbq.push_back(e);
    end
    cyc();
  endtask

  task automatic idle_in(input int g);
    in_valid[g] = 1'b0;
    inj_en[g]   = 1'b0;
    in_data[g]  = 8'h5C;
  endtask

  task automatic drain(input int bound);
    int t;
    logic act;
    t = 0;
    act = 1'b1;
    while (act && t < bound) begin
      act = (sbq.size() != 0);
      for (int g = 0; g < 3; g++) act = act | busy_w[g];
      if (act) begin
        cyc();
        t++;
      end
    end
    if (act) flag("drain_timeout");
  endtask

  task automatic wait_done(input int g, input int bound);
    int n0;
    int t;
    n0 = ndone[g];
    t = 0;
    while (ndone[g] == n0 && t < bound) begin
      cyc();
      t++;
    end
    if (ndone[g] == n0) flag("frame_done_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int t;

    vt[0] = '{8'hA5, 1'b0, 4'd0,  12'hA27};
    vt[1] = '{8'h00, 1'b0, 4'd0,  12'h000};
    vt[2] = '{8'hFF, 1'b0, 4'd0,  12'hF77};
    vt[3] = '{8'h3C, 1'b0, 4'd0,  12'h362};
    vt[4] = '{8'hA5, 1'b1, 4'd5,  12'hA37};
    vt[5] = '{8'hA5, 1'b1, 4'd0,  12'hA27};
    vt[6] = '{8'hA5, 1'b1, 4'd14, 12'hA27};
    vt[7] = '{8'hA5, 1'b1, 4'd12, 12'h227};
    vt[8] = '{8'hA5, 1'b1, 4'd1,  12'hA26};
    vt[9] = '{8'hA5, 1'b0, 4'd5,  12'hA27};

    n_chk = 0;
    n_fail = 0;
    for (int g = 0; g < 3; g++) begin
      fcnt[g] = 0; run[g] = 0; lowrun[g] = 0; last_run[g] = 0; last_gap[g] = 0; ndone[g] = 0;
      cap[g] = '0;
      in_data[g] = '0; in_valid[g] = 1'b0; inj_en[g] = 1'b0; inj_pos[g] = '0;
    end

    // Reset values
    rst = 1'b1;
    repeat (3) cyc();
    for (int g = 0; g < 3; g++) begin
      chk("rst_ser_out", int'(ser_out_w[g]), 1);
      chk("rst_ser_frame", int'(ser_frame_w[g]), 0);
      chk("rst_frame_done", int'(frame_done_w[g]), 0);
      chk("rst_busy", int'(busy_w[g]), 0);
      chk("rst_in_ready", int'(in_ready_w[g]), 1);
      chk("rst_cw_out", int'(cw_out_w[g]), 0);
    end
    rst = 1'b0;
    repeat (2) cyc();

    // Single A5 frame: latency, 48-cycle frame, gap then idle
    send(0, 8'hA5, 1'b0, 4'd0, 12'hA27);
    idle_in(0);
    chk("t1_ready_low_after_accept", int'(in_ready_w[0]), 0);
    chk("t1_not_started_yet", int'(ser_frame_w[0]), 0);
    cyc();
    chk("t1_frame_started", int'(ser_frame_w[0]), 1);
    chk("t1_first_bit12", int'(ser_out_w[0]), 1);
    chk("t1_ready_again", int'(in_ready_w[0]), 1);
    chk("t1_busy", int'(busy_w[0]), 1);
    chk("t1_cw_out", int'(cw_out_w[0]), 12'hA27);
    wait_done(0, 200);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_gap_busy", int'(busy_w[0]), 1);
      chk("t1_gap_frame_low", int'(ser_frame_w[0]), 0);
    end
    cyc();
    chk("t1_idle_busy", int'(busy_w[0]), 0);
    chk("t1_frame_len", last_run[0], 48);

    // 00 then FF: second byte accepted mid-frame, held-byte backpressure, 4-cycle gap
    send(0, 8'h00, 1'b0, 4'd0, 12'h000);
    idle_in(0);
    repeat (2) cyc();
    chk("t2_first_in_frame", int'(ser_frame_w[0]), 1);
    chk("t2_ready_during_frame", int'(in_ready_w[0]), 1);
    send(0, 8'hFF, 1'b0, 4'd0, 12'hF77);
    chk("t2_ready_low_hold_full", int'(in_ready_w[0]), 0);
    in_data[0] = 8'h11;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_ready_stays_low", int'(in_ready_w[0]), 0);
    end
    idle_in(0);
    wait_done(0, 200);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t2_gap_frame_low", int'(ser_frame_w[0]), 0);
      chk("t2_gap_ready_low", int'(in_ready_w[0]), 0);
    end
    cyc();
    chk("t2_second_frame_start", int'(ser_frame_w[0]), 1);
    chk("t2_ready_after_load", int'(in_ready_w[0]), 1);
    chk("t2_gap_len", last_gap[0], 4);
    drain(400);

    // Vector table including injection positions
    for (int i = 0; i < 10; i++) begin
      send(0, vt[i].data, vt[i].en, vt[i].pos, vt[i].cw);
    end
    idle_in(0);
    drain(2000);

    // Contiguous stream with valid held high, no gap
    n0 = ndone[1];
    send(1, 8'hA5, 1'b0, 4'd0, 12'hA27);
    send(1, 8'hFF, 1'b0, 4'd0, 12'hF77);
    send(1, 8'h00, 1'b0, 4'd0, 12'h000);
    send(1, 8'h3C, 1'b0, 4'd0, 12'h362);
    idle_in(1);
    drain(1000);
    cyc();
    chk("t4_frames", ndone[1] - n0, 4);
    chk("t4_contiguous_len", last_run[1], 192);

    // Reset mid-frame with a byte held
    send(0, 8'h3C, 1'b0, 4'd0, 12'h362);
    send(0, 8'h5A, 1'b0, 4'd0, tb_encode(8'h5A));
    idle_in(0);
    chk("t5_hold_full", int'(in_ready_w[0]), 0);
    t = 0;
    while (fcnt[0] != 22 && t < 200) begin
      cyc();
      t++;
    end
    if (fcnt[0] != 22) flag("t5_reach_bit6");
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_ser_out", int'(ser_out_w[0]), 1);
    chk("t5_rst_ser_frame", int'(ser_frame_w[0]), 0);
    chk("t5_rst_busy", int'(busy_w[0]), 0);
    chk("t5_rst_ready", int'(in_ready_w[0]), 1);
    chk("t5_rst_cw_out", int'(cw_out_w[0]), 0);
    chk("t5_rst_frame_done", int'(frame_done_w[0]), 0);
    sbq.delete();
    repeat (2) cyc();
    rst = 1'b0;
    n0 = ndone[0];
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (ser_frame_w[0]) begin
        flag("t5_held_byte_sent");
        break;
      end
    end
    chk("t5_no_frames", ndone[0] - n0, 0);
    send(0, 8'hC3, 1'b0, 4'd0, tb_encode(8'hC3));
    idle_in(0);
    drain(200);
    chk("t5_fresh_frame", ndone[0] - n0, 1);

    // Loopback of every byte with every injection position, one clock per bit
    for (int d = 0; d < 256; d++) begin
      for (int p = 0; p <= 12; p++) begin
        send(2, 8'(d), 1'b1, 4'(p), tb_encode(8'(d)) ^ pos_mask(p));
      end
    end
    idle_in(2);
    drain(1000);
    chk("t6_frames", ndone[2], 256 * 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
